// File: rtl/fetch_pipe_unit.sv
// fetch_pipe_unit: fetch-to-decode pipeline register with a 2-entry replay buffer for responses landing during decode stalls
module fetch_pipe_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 20,
  parameter logic [DATA_WIDTH-1:0] NOP = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [1:0]              next_PC_select_execute,
  input  logic [1:0]              next_PC_select_memory,
  input  logic [DATA_WIDTH-1:0]   instruction_fetch,
  input  logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  input  logic                    inst_valid_fetch,
  output logic [DATA_WIDTH-1:0]   instruction_decode,
  output logic [ADDRESS_BITS-1:0] inst_PC_decode,
  output logic                    valid_decode,
  output logic                    fetch_hold,
  output logic [1:0]              buffer_count,
  output logic                    overflow_error,
  output logic [15:0]             flush_count
);
  logic [DATA_WIDTH-1:0]   buf_inst [2];
  logic [ADDRESS_BITS-1:0] buf_pc [2];
  logic                    rd_ptr, wr_ptr;
  logic                    flush, occupied, push, pop, drop;
  assign flush = |next_PC_select_execute || |next_PC_select_memory;
  assign occupied = |buffer_count;
  // an advancing cycle with an empty buffer bypasses straight to the outputs instead of pushing
  assign push = inst_valid_fetch && !flush && (stall ? buffer_count != 2'd2 : occupied);
  assign pop = !flush && !stall && occupied;
  assign drop = inst_valid_fetch && !flush && stall && buffer_count == 2'd2;
  assign fetch_hold = stall || occupied;
  always_ff @(posedge clock) begin
    if (push) begin
      buf_inst[wr_ptr] <= instruction_fetch;
      buf_pc[wr_ptr] <= inst_PC_fetch;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction_decode <= NOP;
      inst_PC_decode <= '0;
      valid_decode <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      buffer_count <= 2'd0;
      overflow_error <= 1'b0;
      flush_count <= 16'd0;
    end else begin
      if (flush) begin
        instruction_decode <= NOP;
        inst_PC_decode <= '0;
        valid_decode <= 1'b0;
      end else if (!stall) begin
        instruction_decode <= occupied ? buf_inst[rd_ptr] : inst_valid_fetch ? instruction_fetch : NOP;
        inst_PC_decode <= occupied ? buf_pc[rd_ptr] : inst_valid_fetch ? inst_PC_fetch : '0;
        valid_decode <= occupied || inst_valid_fetch;
      end
      rd_ptr <= flush ? 1'b0 : rd_ptr ^ pop;
      wr_ptr <= flush ? 1'b0 : wr_ptr ^ push;
      buffer_count <= flush ? 2'd0 : buffer_count + 2'(push) - 2'(pop);
      overflow_error <= overflow_error || drop;
      flush_count <= flush && !(&flush_count) ? flush_count + 16'd1 : flush_count;
    end
  end
endmodule
